pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL, default 1, giving the bubbles inserted per load-use hazard (legal 1..3).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the stall counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 en  input  1  global pipeline enable.
REQ-007 AA, BA  input  5 each  DOF-stage source register addresses.
REQ-008 MA, MB  input  1 each  DOF-stage operand selects; 1 = constant or PC, not a register.
REQ-009 RW_1  input  1  EX-stage register write enable.
REQ-010 DA_1  input  5  EX-stage destination register.
REQ-011 MD_1  input  2  EX-stage write-back source; 2'b01 = data memory.
REQ-012 br_taken  input  1  branch or jump resolved taken in EX.
REQ-013 clr_cnt  input  1  synchronous clear of stall_cnt.
REQ-014 stall  output  1  hold PC and IF/DOF registers.
REQ-015 bubble  output  1  force a NOP (RW=0, MW=0) into DOF->EX.
REQ-016 flush  output  1  invalidate IF->DOF.
REQ-017 busy  output  1  FSM not in RUN.
REQ-018 stall_cnt  output  CNT_W  saturating count of hazard stall cycles.

Function
REQ-019 ld_haz SHALL be RW_1 & (DA_1!=0) & (MD_1==2'b01) & ((~MA & AA==DA_1) | (~MB & BA==DA_1)); R0 never raises a hazard.
REQ-020 The FSM SHALL have the states RUN, LDSTALL and FLUSH.
REQ-021 RUN, br_taken=1: flush=1 and bubble=1 in the same cycle; next state FLUSH.
REQ-022 RUN, ld_haz=1, br_taken=0: stall=1 and bubble=1 in the same cycle. Next state is LDSTALL if LOAD_STALL>1, else RUN.
REQ-023 RUN, neither condition: all control outputs 0; remain in RUN.
REQ-024 br_taken SHALL take priority over ld_haz in the same cycle.
REQ-025 LDSTALL: stall=1 and bubble=1 for exactly LOAD_STALL-1 cycles, timed by an internal down-counter; then RUN.
REQ-026 LDSTALL: br_taken and ld_haz SHALL be ignored.
REQ-027 Total hazard stall per load-use SHALL be exactly LOAD_STALL cycles.
REQ-028 FLUSH: flush=1, stall=0, bubble=0 for one cycle; hazards ignored; then RUN. Branch penalty is 2 cycles.
REQ-029 en=0: state, internal counter and stall_cnt SHALL hold; stall=1, bubble=0, flush=0.
REQ-030 stall_cnt SHALL increment on each enabled cycle in which stall=1, and saturate at all-ones.
REQ-031 clr_cnt SHALL override increment and zero stall_cnt on the next edge, regardless of en.
REQ-032 busy SHALL be 1 exactly when state!=RUN; it is registered and glitch-free.

Reset
REQ-033 reset=0 SHALL asynchronously force state=RUN, internal counter=0 and stall_cnt=0.
REQ-034 Outputs while in reset: stall=0, bubble=0, flush=0, busy=0.
REQ-035 Reset asserted mid-LDSTALL or mid-FLUSH SHALL abandon the sequence; no residual bubble after release.
REQ-036 First hazard evaluation SHALL occur on the first rising edge after reset release.

Structure
REQ-037 The state encoding and MD_MEM=2'b01 SHALL live in the shared RISC package; LOAD_STALL and CNT_W stay module parameters.
REQ-038 Hazard detection (REQ-019) SHALL be one combinational sub-module, load_use_detect, reused by the forwarding logic owners.
REQ-039 The FSM, counters and output decode SHALL be in pipeline_hazard_ctrl.

Verification
REQ-040 Load-use: LOAD_STALL=1; AA=5, MA=0, RW_1=1, DA_1=5, MD_1=01 -> stall=bubble=1 for 1 cycle; busy=0; stall_cnt=1.
REQ-041 R0 and constant-select: DA_1=0, or BA==DA_1 with MB=1 -> no stall, bubble or flush.
REQ-042 Branch beats hazard: br_taken=1 with ld_haz=1 -> cycle 1 flush=bubble=1, stall=0; cycle 2 flush=1, busy=1; cycle 3 RUN; stall_cnt unchanged.
REQ-043 LOAD_STALL=3: one load-use -> stall=1 for 3 consecutive cycles, busy=1 on cycles 2-3; stall_cnt +3.
REQ-044 en=0 inserted in LDSTALL -> state and counters frozen with stall=1; remaining stall cycles resume after en=1.
REQ-045 Saturation/reset: CNT_W=4 with 20 hazard cycles -> stall_cnt=4'hF; reset=0 mid-LDSTALL -> outputs 0 immediately, busy=0 after release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared RISC pipeline definitions: hazard FSM state encoding and write-back select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  // Hazard controller FSM states.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } hz_state_t;

  // Write-back source code selecting data memory (i.e. the EX instruction is a load).
  localparam logic [1:0] MD_MEM = 2'b01;

  // Register file address width.
  localparam int REG_AW = 5;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a DOF-stage register source matches the destination of a load in EX.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the hazard FSM and by forwarding logic.
// Ports: AA/BA source addresses, MA/MB operand selects (1 = non-register operand),
//        RW_1/DA_1/MD_1 EX-stage write enable, destination and write-back source; ld_haz result.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] AA,
  input  logic [REG_AW-1:0] BA,
  input  logic              MA,
  input  logic              MB,
  input  logic              RW_1,
  input  logic [REG_AW-1:0] DA_1,
  input  logic [1:0]        MD_1,
  output logic              ld_haz
);

  logic a_match;
  logic b_match;
  logic ex_is_load;

  // A source only counts when the operand actually comes from the register file.
  assign a_match    = ~MA & (AA == DA_1);
  assign b_match    = ~MB & (BA == DA_1);
  // R0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign ex_is_load = RW_1 & (DA_1 != '0) & (MD_1 == MD_MEM);
  assign ld_haz     = ex_is_load & (a_match | b_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and a saturating stall counter.
// Latency: control outputs react combinationally in the hazard cycle; busy is registered.
// Backpressure: en=0 freezes the FSM and counters and holds the front end with stall=1.
// Ports: clk, reset (async active-low), en, DOF sources AA/BA/MA/MB, EX destination RW_1/DA_1/MD_1,
//        br_taken, clr_cnt; outputs stall, bubble, flush, busy, stall_cnt.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [REG_AW-1:0] AA,
  input  logic [REG_AW-1:0] BA,
  input  logic              MA,
  input  logic              MB,
  input  logic              RW_1,
  input  logic [REG_AW-1:0] DA_1,
  input  logic [1:0]        MD_1,
  input  logic              br_taken,
  input  logic              clr_cnt,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The first stall cycle is spent in RUN, so LDSTALL covers the remaining
  // LOAD_STALL-1 cycles: the down-counter loads LOAD_STALL-2 and exits at zero.
  localparam int         RELOAD   = (LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0;
  localparam logic [1:0] RELOAD_V = RELOAD[1:0];

  hz_state_t  state;
  hz_state_t  state_nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic       busy_q;
  logic       ld_haz;

  load_use_detect u_detect (
    .AA     (AA),
    .BA     (BA),
    .MA     (MA),
    .MB     (MB),
    .RW_1   (RW_1),
    .DA_1   (DA_1),
    .MD_1   (MD_1),
    .ld_haz (ld_haz)
  );

  // State register. busy is registered from the next state so it is a clean flop output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_RUN;
      cnt    <= 2'd0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= (state_nxt != ST_RUN);
    end
  end

  // Next-state logic. Hazards are only sampled in RUN; a taken branch wins over a load-use.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (en) begin
      case (state)
        ST_RUN: begin
          if (br_taken) begin
            state_nxt = ST_FLUSH;
          end else if (ld_haz && (LOAD_STALL > 1)) begin
            state_nxt = ST_LDSTALL;
            cnt_nxt   = RELOAD_V;
          end
        end
        ST_LDSTALL: begin
          if (cnt == 2'd0) begin
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
        ST_FLUSH: state_nxt = ST_RUN;
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  // Output decode. Gated by reset so nothing leaks out while reset is held,
  // even with en=0 or live hazard inputs.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (reset) begin
      if (!en) begin
        stall = 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            if (br_taken) begin
              flush  = 1'b1;
              bubble = 1'b1;
            end else if (ld_haz) begin
              stall  = 1'b1;
              bubble = 1'b1;
            end
          end
          ST_LDSTALL: begin
            stall  = 1'b1;
            bubble = 1'b1;
          end
          ST_FLUSH: flush = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign busy = busy_q;

  // Counts enabled hazard-stall cycles only; stalls caused by en=0 are not hazards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (en && stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances share stimulus.
// dut_a: LOAD_STALL=1, CNT_W=4 (single-cycle stall, saturation); dut_b: LOAD_STALL=3, CNT_W=16.
// Outputs are checked 2 time units after the rising edge, inputs change 1 unit after it.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  AA;
  logic [4:0]  BA;
  logic        MA;
  logic        MB;
  logic        RW_1;
  logic [4:0]  DA_1;
  logic [1:0]  MD_1;
  logic        br_taken;
  logic        clr_cnt;

  logic        stall_a, bubble_a, flush_a, busy_a;
  logic [3:0]  cnt_a;
  logic        stall_b, bubble_b, flush_b, busy_b;
  logic [15:0] cnt_b;

  int checks;
  int errors;

  pipeline_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .en(en),
    .AA(AA), .BA(BA), .MA(MA), .MB(MB),
    .RW_1(RW_1), .DA_1(DA_1), .MD_1(MD_1),
    .br_taken(br_taken), .clr_cnt(clr_cnt),
    .stall(stall_a), .bubble(bubble_a), .flush(flush_a), .busy(busy_a),
    .stall_cnt(cnt_a)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .en(en),
    .AA(AA), .BA(BA), .MA(MA), .MB(MB),
    .RW_1(RW_1), .DA_1(DA_1), .MD_1(MD_1),
    .br_taken(br_taken), .clr_cnt(clr_cnt),
    .stall(stall_b), .bubble(bubble_b), .flush(flush_b), .busy(busy_b),
    .stall_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      $error("%s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    AA = 5'd0; BA = 5'd0; MA = 1'b1; MB = 1'b1;
    RW_1 = 1'b0; DA_1 = 5'd0; MD_1 = 2'b00; br_taken = 1'b0;
  endtask

  // Load into R5 in EX, DOF reads R5 on port A.
  task automatic haz();
    AA = 5'd5; BA = 5'd0; MA = 1'b0; MB = 1'b1;
    RW_1 = 1'b1; DA_1 = 5'd5; MD_1 = 2'b01; br_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held with en=0, a load-use and a taken branch all present: outputs stay quiet.
    reset = 1'b0; en = 1'b0; clr_cnt = 1'b0;
    haz(); br_taken = 1'b1;
    #3;
    chk("rst_stall_a",  {31'd0, stall_a},  32'd0);
    chk("rst_bubble_a", {31'd0, bubble_a}, 32'd0);
    chk("rst_flush_a",  {31'd0, flush_a},  32'd0);
    chk("rst_busy_a",   {31'd0, busy_a},   32'd0);
    chk("rst_cnt_a",    {28'd0, cnt_a},    32'd0);
    chk("rst_stall_b",  {31'd0, stall_b},  32'd0);
    chk("rst_busy_b",   {31'd0, busy_b},   32'd0);

    @(posedge clk); #2;
    reset = 1'b1; en = 1'b1; idle();
    #1;
    chk("idle_stall_a", {31'd0, stall_a}, 32'd0);
    step();

    // Load-use on port A.
    haz(); #1;
    chk("ld_stall_a",  {31'd0, stall_a},  32'd1);
    chk("ld_bubble_a", {31'd0, bubble_a}, 32'd1);
    chk("ld_flush_a",  {31'd0, flush_a},  32'd0);
    chk("ld_busy_a",   {31'd0, busy_a},   32'd0);
    chk("ld_stall_b",  {31'd0, stall_b},  32'd1);
    chk("ld_busy_b",   {31'd0, busy_b},   32'd0);
    step(); idle(); #1;
    chk("ld1_stall_a",  {31'd0, stall_a},  32'd0);
    chk("ld1_busy_a",   {31'd0, busy_a},   32'd0);
    chk("ld1_cnt_a",    {28'd0, cnt_a},    32'd1);
    chk("ld1_stall_b",  {31'd0, stall_b},  32'd1);
    chk("ld1_bubble_b", {31'd0, bubble_b}, 32'd1);
    chk("ld1_busy_b",   {31'd0, busy_b},   32'd1);
    chk("ld1_cnt_b",    {16'd0, cnt_b},    32'd1);
    step(); #1;
    chk("ld2_stall_b", {31'd0, stall_b}, 32'd1);
    chk("ld2_busy_b",  {31'd0, busy_b},  32'd1);
    chk("ld2_cnt_b",   {16'd0, cnt_b},   32'd2);
    step(); #1;
    chk("ld3_stall_b", {31'd0, stall_b}, 32'd0);
    chk("ld3_busy_b",  {31'd0, busy_b},  32'd0);
    chk("ld3_cnt_b",   {16'd0, cnt_b},   32'd3);
    chk("ld3_cnt_a",   {28'd0, cnt_a},   32'd1);

    // R0 destination, constant-selected operand, non-load write-back.
    RW_1 = 1'b1; MD_1 = 2'b01; DA_1 = 5'd0; AA = 5'd0; BA = 5'd0; MA = 1'b0; MB = 1'b0;
    #1;
    chk("r0_stall_a",  {31'd0, stall_a},  32'd0);
    chk("r0_bubble_a", {31'd0, bubble_a}, 32'd0);
    chk("r0_stall_b",  {31'd0, stall_b},  32'd0);
    DA_1 = 5'd7; BA = 5'd7; MB = 1'b1; AA = 5'd3; MA = 1'b0;
    #1;
    chk("mb_stall_a",  {31'd0, stall_a},  32'd0);
    chk("mb_bubble_a", {31'd0, bubble_a}, 32'd0);
    chk("mb_flush_a",  {31'd0, flush_a},  32'd0);
    MB = 1'b0;
    #1;
    chk("bport_stall_a", {31'd0, stall_a}, 32'd1);
    MD_1 = 2'b10;
    #1;
    chk("alu_stall_a", {31'd0, stall_a}, 32'd0);
    idle();
    step();

    // Clear with en=0: front end held, counters zeroed anyway.
    en = 1'b0; clr_cnt = 1'b1; #1;
    chk("dis_stall_a",  {31'd0, stall_a},  32'd1);
    chk("dis_bubble_a", {31'd0, bubble_a}, 32'd0);
    chk("dis_flush_a",  {31'd0, flush_a},  32'd0);
    step(); clr_cnt = 1'b0; en = 1'b1; #1;
    chk("clr_cnt_a", {28'd0, cnt_a}, 32'd0);
    chk("clr_cnt_b", {16'd0, cnt_b}, 32'd0);

    // Taken branch together with a load-use: branch wins, then one FLUSH cycle.
    haz(); br_taken = 1'b1; #1;
    chk("br_flush_a",  {31'd0, flush_a},  32'd1);
    chk("br_bubble_a", {31'd0, bubble_a}, 32'd1);
    chk("br_stall_a",  {31'd0, stall_a},  32'd0);
    chk("br_flush_b",  {31'd0, flush_b},  32'd1);
    chk("br_stall_b",  {31'd0, stall_b},  32'd0);
    step(); haz(); #1;
    chk("fl_flush_a",  {31'd0, flush_a},  32'd1);
    chk("fl_stall_a",  {31'd0, stall_a},  32'd0);
    chk("fl_bubble_a", {31'd0, bubble_a}, 32'd0);
    chk("fl_busy_a",   {31'd0, busy_a},   32'd1);
    chk("fl_flush_b",  {31'd0, flush_b},  32'd1);
    chk("fl_busy_b",   {31'd0, busy_b},   32'd1);
    step(); idle(); #1;
    chk("br3_flush_a", {31'd0, flush_a}, 32'd0);
    chk("br3_busy_a",  {31'd0, busy_a},  32'd0);
    chk("br3_cnt_a",   {28'd0, cnt_a},   32'd0);
    chk("br3_cnt_b",   {16'd0, cnt_b},   32'd0);

    // en=0 while dut_b is in LDSTALL.
    haz(); step();
    en = 1'b0; idle(); #1;
    chk("frz_stall_b",  {31'd0, stall_b},  32'd1);
    chk("frz_bubble_b", {31'd0, bubble_b}, 32'd0);
    chk("frz_busy_b",   {31'd0, busy_b},   32'd1);
    step(); step(); #1;
    chk("frz2_busy_b", {31'd0, busy_b}, 32'd1);
    chk("frz2_cnt_b",  {16'd0, cnt_b},  32'd1);
    chk("frz2_cnt_a",  {28'd0, cnt_a},  32'd1);
    en = 1'b1; #1;
    chk("res1_stall_b",  {31'd0, stall_b},  32'd1);
    chk("res1_bubble_b", {31'd0, bubble_b}, 32'd1);
    step(); #1;
    chk("res2_stall_b", {31'd0, stall_b}, 32'd1);
    chk("res2_busy_b",  {31'd0, busy_b},  32'd1);
    chk("res2_cnt_b",   {16'd0, cnt_b},   32'd2);
    step(); #1;
    chk("res3_stall_b", {31'd0, stall_b}, 32'd0);
    chk("res3_busy_b",  {31'd0, busy_b},  32'd0);
    chk("res3_cnt_b",   {16'd0, cnt_b},   32'd3);
    chk("res3_cnt_a",   {28'd0, cnt_a},   32'd1);

    // Saturation: 20 consecutive hazard-stall cycles.
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    haz();
    repeat (20) step();
    idle(); #1;
    chk("sat_cnt_a", {28'd0, cnt_a}, 32'd15);
    chk("sat_cnt_b", {16'd0, cnt_b}, 32'd20);
    haz(); clr_cnt = 1'b1; step(); clr_cnt = 1'b0; idle(); #1;
    chk("clrovr_cnt_a", {28'd0, cnt_a}, 32'd0);
    step(); step(); step();

    // Reset in the middle of LDSTALL.
    haz(); step(); idle(); #1;
    chk("pre_rst_busy_b",  {31'd0, busy_b},  32'd1);
    chk("pre_rst_stall_b", {31'd0, stall_b}, 32'd1);
    reset = 1'b0; #1;
    chk("mid_rst_stall_b",  {31'd0, stall_b},  32'd0);
    chk("mid_rst_bubble_b", {31'd0, bubble_b}, 32'd0);
    chk("mid_rst_busy_b",   {31'd0, busy_b},   32'd0);
    chk("mid_rst_stall_a",  {31'd0, stall_a},  32'd0);
    #2; reset = 1'b1; #1;
    chk("rel_stall_b", {31'd0, stall_b}, 32'd0);
    chk("rel_busy_b",  {31'd0, busy_b},  32'd0);
    step(); #1;
    chk("post_stall_b",  {31'd0, stall_b},  32'd0);
    chk("post_bubble_b", {31'd0, bubble_b}, 32'd0);
    chk("post_busy_b",   {31'd0, busy_b},   32'd0);
    chk("post_cnt_b",    {16'd0, cnt_b},    32'd0);
    chk("post_cnt_a",    {28'd0, cnt_a},    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
